flit_meta_unpacker: RTL and testbench



---
 rtl/flit_meta_unpacker.sv | 140 ++++++++++++++
 tb/tb_flit_meta_unpacker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/flit_meta_unpacker.sv
// Ingress unpacker ahead of the flit decompressor: latches per-packet base/encoding
// metadata from the head flit and tags each following body flit with its pair.
module flit_meta_unpacker #(
    parameter int FLIT_WIDTH = 128,
    parameter int CHUNK_SIZE = 8,
    parameter int EN_BITS    = 3,
    parameter int NUM_PAIRS  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  is_head,
    input  logic                  is_tail,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [EN_BITS-1:0]    en_bits,
    output logic [CHUNK_SIZE-1:0] base,
    output logic                  out_bypass,
    output logic                  out_last,
    output logic                  proto_err
);

    // state | meaning
    // IDLE  | waiting for a head flit; non-head flits are dropped with proto_err
    // BODY  | metadata latched; body flits take pair[cnt]

    localparam int PAIR_W = EN_BITS + CHUNK_SIZE;
    localparam int META_W = NUM_PAIRS * PAIR_W;
    localparam int CNT_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PAIRS - 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [META_W-1:0] meta_reg, meta_next;
    // Set once the last pair has been handed out; a further body flit is an overrun.
    logic              sat, sat_next;
    logic              err_next;

    logic                  xfer_in;
    logic                  load;
    logic                  bypass_next;
    logic [EN_BITS-1:0]    en_next;
    logic [CHUNK_SIZE-1:0] base_next;
    logic [PAIR_W-1:0]     pairs [NUM_PAIRS];
    logic [PAIR_W-1:0]     pair_sel;

    assign in_ready = !out_valid || out_ready;
    assign xfer_in  = in_valid && in_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            meta_reg <= '0;
            sat      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            meta_reg <= meta_next;
            sat      <= sat_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        meta_next  = meta_reg;
        sat_next   = sat;
        err_next   = 1'b0;
        if (xfer_in) begin
            if (is_head) begin
                meta_next  = flit_in[META_W-1:0];
                cnt_next   = '0;
                sat_next   = 1'b0;
                state_next = is_tail ? IDLE : BODY;
                if (state == BODY) err_next = 1'b1;
            end else if (state == IDLE) begin
                err_next = 1'b1;
            end else begin
                if (sat) err_next = 1'b1;
                if (cnt == CNT_MAX) sat_next = 1'b1;
                else                cnt_next = cnt + 1'b1;
                if (is_tail) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end
        end
    end

    // Pair 0 sits in the most significant slice of the metadata field.
    always_comb begin
        for (int k = 0; k < NUM_PAIRS; k++) begin
            pairs[k] = meta_reg[META_W-1-k*PAIR_W -: PAIR_W];
        end
    end

    assign pair_sel = pairs[cnt];

    always_comb begin
        load        = xfer_in && (is_head || state == BODY);
        bypass_next = is_head;
        en_next     = '0;
        base_next   = '0;
        if (!is_head) begin
            {en_next, base_next} = pair_sel;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            en_bits    <= '0;
            base       <= '0;
            out_bypass <= 1'b0;
            out_last   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            proto_err <= err_next;
            if (load) begin
                out_valid  <= 1'b1;
                data_out   <= flit_in;
                en_bits    <= en_next;
                base       <= base_next;
                out_bypass <= bypass_next;
                out_last   <= is_tail;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flit_meta_unpacker.sv
// Directed bench for flit_meta_unpacker: hand-computed expectations checked with
// immediate assertions after each clock.
module tb_flit_meta_unpacker;

    localparam logic [43:0] META_A = {3'd5, 8'h10, 3'd1, 8'h20, 3'd7, 8'hFF, 3'd0, 8'h00};
    localparam logic [43:0] META_B = {3'd2, 8'h33, 3'd4, 8'h44, 3'd6, 8'h55, 3'd3, 8'h66};
    localparam logic [127:0] HEAD_A = {84'hDEADBEEF0123456789ABC, META_A};
    localparam logic [127:0] HEAD_B = {84'h13579BDF02468ACE01234, META_B};
    localparam logic [127:0] BODY0  = 128'hB0D0_0000_1111_2222_3333_4444_5555_0000;
    localparam logic [127:0] BODY1  = 128'hB0D1_0101_1111_2222_3333_4444_5555_0001;
    localparam logic [127:0] BODY2  = 128'hB0D2_0202_1111_2222_3333_4444_5555_0002;
    localparam logic [127:0] BODY3  = 128'hB0D3_0303_1111_2222_3333_4444_5555_0003;
    localparam logic [127:0] BODY4  = 128'hB0D4_0404_1111_2222_3333_4444_5555_0004;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] flit_in = '0;
    logic         is_head = 1'b0;
    logic         is_tail = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] data_out;
    logic [2:0]   en_bits;
    logic [7:0]   base;
    logic         out_bypass;
    logic         out_last;
    logic         proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    flit_meta_unpacker dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flit_in   (flit_in),
        .is_head   (is_head),
        .is_tail   (is_tail),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .en_bits   (en_bits),
        .base      (base),
        .out_bypass(out_bypass),
        .out_last  (out_last),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [127:0] f, input logic h, input logic t);
        in_valid = v;
        flit_in  = f;
        is_head  = h;
        is_tail  = t;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [127:0] d,
                           input logic [2:0] e, input logic [7:0] b,
                           input logic byp, input logic last, input logic err);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".err"}, proto_err, err);
        if (v) begin
            chk({tag, ".data"}, data_out, d);
            chk({tag, ".en"}, en_bits, e);
            chk({tag, ".base"}, base, b);
            chk({tag, ".bypass"}, out_bypass, byp);
            chk({tag, ".last"}, out_last, last);
        end
    endtask

    initial begin
        // reset state
        #2;
        chk_out("rst", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst.data", data_out, '0);
        chk("rst.in_ready", in_ready, 1'b1);
        #10 rst = 1'b0;
        tick();

        // full packet, back to back, out_ready high
        drive(1'b1, HEAD_A, 1'b1, 1'b0); tick();
        chk_out("p1.head", 1'b1, HEAD_A, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p1.b0", 1'b1, BODY0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY1, 1'b0, 1'b0); tick();
        chk_out("p1.b1", 1'b1, BODY1, 3'd1, 8'h20, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY2, 1'b0, 1'b0); tick();
        chk_out("p1.b2", 1'b1, BODY2, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY3, 1'b0, 1'b1); tick();
        chk_out("p1.b3", 1'b1, BODY3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk_out("p1.drain", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // same packet with a 3-cycle downstream stall
        drive(1'b1, HEAD_A, 1'b1, 1'b0); tick();
        chk_out("p2.head", 1'b1, HEAD_A, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p2.b0", 1'b1, BODY0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY1, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("p2.in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("p2.stall", 1'b1, BODY0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0);
            chk("p2.stall_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("p2.in_ready_high", in_ready, 1'b1);
        tick();
        chk_out("p2.b1", 1'b1, BODY1, 3'd1, 8'h20, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY2, 1'b0, 1'b0); tick();
        chk_out("p2.b2", 1'b1, BODY2, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY3, 1'b0, 1'b1); tick();
        chk_out("p2.b3", 1'b1, BODY3, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk_out("p2.drain", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // body flit in IDLE is dropped; FSM stays in IDLE
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p3.drop", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk_out("p3.pulse_end", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY1, 1'b0, 1'b0); tick();
        chk_out("p3.still_idle", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0); tick();

        // head, 2 bodies, new head without a tail
        drive(1'b1, HEAD_A, 1'b1, 1'b0); tick();
        chk_out("p4.head", 1'b1, HEAD_A, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p4.b0", 1'b1, BODY0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY1, 1'b0, 1'b0); tick();
        chk_out("p4.b1", 1'b1, BODY1, 3'd1, 8'h20, 1'b0, 1'b0, 1'b0);
        drive(1'b1, HEAD_B, 1'b1, 1'b0); tick();
        chk_out("p4.head2", 1'b1, HEAD_B, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);
        drive(1'b1, BODY2, 1'b0, 1'b0); tick();
        chk_out("p4.b_new0", 1'b1, BODY2, 3'd2, 8'h33, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY3, 1'b0, 1'b1); tick();
        chk_out("p4.b_new1", 1'b1, BODY3, 3'd4, 8'h44, 1'b0, 1'b1, 1'b0);

        // overrun: 5 body flits, no tail
        drive(1'b1, HEAD_B, 1'b1, 1'b0); tick();
        chk_out("p5.head", 1'b1, HEAD_B, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p5.b0", 1'b1, BODY0, 3'd2, 8'h33, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY1, 1'b0, 1'b0); tick();
        chk_out("p5.b1", 1'b1, BODY1, 3'd4, 8'h44, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY2, 1'b0, 1'b0); tick();
        chk_out("p5.b2", 1'b1, BODY2, 3'd6, 8'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY3, 1'b0, 1'b0); tick();
        chk_out("p5.b3", 1'b1, BODY3, 3'd3, 8'h66, 1'b0, 1'b0, 1'b0);
        drive(1'b1, BODY4, 1'b0, 1'b0); tick();
        chk_out("p5.b4", 1'b1, BODY4, 3'd3, 8'h66, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk_out("p5.pulse_end", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // head+tail while in BODY: error, bypass, back to IDLE
        drive(1'b1, HEAD_A, 1'b1, 1'b1); tick();
        chk_out("p6.head_tail", 1'b1, HEAD_A, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p6.idle_drop", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);

        // reset mid-packet with a flit held
        drive(1'b1, HEAD_A, 1'b1, 1'b0); tick();
        drive(1'b1, BODY0, 1'b0, 1'b0); tick();
        chk_out("p7.pre", 1'b1, BODY0, 3'd5, 8'h10, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("p7.rst", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("p7.rst_data", data_out, '0);
        chk("p7.rst_en", en_bits, 3'd0);
        chk("p7.rst_bypass", out_bypass, 1'b0);
        chk("p7.rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(1'b1, BODY1, 1'b0, 1'b0); tick();
        chk_out("p7.drop", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, HEAD_B, 1'b1, 1'b0); tick();
        chk_out("p7.head", 1'b1, HEAD_B, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, BODY2, 1'b0, 1'b1); tick();
        chk_out("p7.b0", 1'b1, BODY2, 3'd2, 8'h33, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        chk_out("p7.drain", 1'b0, '0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
